// File: rtl/tick_gen_multi.sv
// tick_gen_multi: N_CH programmable game-tick channels plus a divided pixel enable.
// Every output is a single-cycle enable in the clk_i domain. No derived clocks are generated.
// Optional feature: define TICKGEN_TOGGLE_EN to add a per-channel square-wave output, toggle_o.
module tick_gen_multi #(
    parameter int unsigned                  N_CH       = 2,
    parameter int unsigned                  CNT_W      = 25,
    parameter int unsigned                  PIX_DIV    = 2,
    parameter logic [N_CH*CNT_W-1:0]        DEF_PERIOD = {25'd75000, 25'd200000},
    localparam int unsigned                 CH_W       = $clog2(N_CH) | 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic                 sync_i,
    input  logic                 cfg_we_i,
    input  logic [CH_W-1:0]      cfg_ch_i,
    input  logic [CNT_W-1:0]     cfg_period_i,
    output logic [N_CH-1:0]      tick_o,
`ifdef TICKGEN_TOGGLE_EN
    output logic [N_CH-1:0]      toggle_o,
`endif
    output logic                 pix_en_o
);

    localparam int unsigned PCNT_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    logic [CNT_W-1:0]  cnt_q    [N_CH];
    logic [CNT_W-1:0]  cnt_d    [N_CH];
    logic [CNT_W-1:0]  period_q [N_CH];
    logic [CNT_W-1:0]  period_d [N_CH];
    logic [N_CH-1:0]   wr_sel;
    logic [N_CH-1:0]   tick_d;
    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic              pix_en_d;

    // Decode the config write. An out-of-range index matches no channel, so the write is dropped.
    always_comb begin
        wr_sel = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            wr_sel[k] = cfg_we_i && (cfg_ch_i == CH_W'(k));
        end
    end

    // Channel next state: a write or sync clears the counter, en_i=0 freezes it, otherwise it counts to the period.
    always_comb begin
        tick_d = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            cnt_d[k]    = cnt_q[k];
            period_d[k] = period_q[k];
            if (wr_sel[k]) begin
                period_d[k] = cfg_period_i;
            end
            if (wr_sel[k] || sync_i) begin
                cnt_d[k] = '0;
            end else if (en_i) begin
                if (cnt_q[k] == period_q[k]) begin
                    cnt_d[k]  = '0;
                    tick_d[k] = 1'b1;
                end else begin
                    cnt_d[k] = cnt_q[k] + CNT_W'(1);
                end
            end
        end
    end

    // Pixel divider: runs freely and is not affected by en_i or sync_i.
    always_comb begin
        pix_en_d = (pcnt_q == PCNT_W'(PIX_DIV - 1));
        pcnt_d   = pix_en_d ? '0 : pcnt_q + PCNT_W'(1);
    end

    // Channel state and tick register, with reset loading the default periods.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned k = 0; k < N_CH; k++) begin
                cnt_q[k]    <= '0;
                period_q[k] <= DEF_PERIOD[k*CNT_W +: CNT_W];
            end
            tick_o <= '0;
        end else begin
            for (int unsigned k = 0; k < N_CH; k++) begin
                cnt_q[k]    <= cnt_d[k];
                period_q[k] <= period_d[k];
            end
            tick_o <= tick_d;
        end
    end

`ifdef TICKGEN_TOGGLE_EN
    // Square wave: flips whenever a tick is issued, so it holds through freezes, syncs and writes.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            toggle_o <= '0;
        end else begin
            toggle_o <= toggle_o ^ tick_d;
        end
    end
`endif

    // Pixel counter and registered pixel enable.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pcnt_q   <= '0;
            pix_en_o <= 1'b0;
        end else begin
            pcnt_q   <= pcnt_d;
            pix_en_o <= pix_en_d;
        end
    end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Scoreboard bench for tick_gen_multi.
// u_dut0 is the 2-channel reference configuration with PIX_DIV=2.
// u_dut1 has 3 channels and PIX_DIV=1; its 3-bit channel index can address a channel that does not exist.
module tb_tick_gen_multi;

    logic       clk = 1'b0;
    logic       rst_n, en, sync;
    logic       we0, we1;
    logic [0:0] ch0;
    logic [2:0] ch1;
    logic [7:0] per_in;
    logic [1:0] tick0;
    logic [2:0] tick1;
    logic       pix0, pix1;
`ifdef TICKGEN_TOGGLE_EN
    logic [1:0] tog0;
    logic [2:0] tog1;
`endif

    always #5 clk = ~clk;

    tick_gen_multi #(
        .N_CH(2), .CNT_W(8), .PIX_DIV(2), .DEF_PERIOD({8'd2, 8'd4})
    ) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .sync_i(sync),
        .cfg_we_i(we0), .cfg_ch_i(ch0), .cfg_period_i(per_in),
        .tick_o(tick0),
`ifdef TICKGEN_TOGGLE_EN
        .toggle_o(tog0),
`endif
        .pix_en_o(pix0)
    );

    tick_gen_multi #(
        .N_CH(3), .CNT_W(8), .PIX_DIV(1), .DEF_PERIOD({8'd6, 8'd2, 8'd4})
    ) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .sync_i(sync),
        .cfg_we_i(we1), .cfg_ch_i(ch1), .cfg_period_i(per_in),
        .tick_o(tick1),
`ifdef TICKGEN_TOGGLE_EN
        .toggle_o(tog1),
`endif
        .pix_en_o(pix1)
    );

    typedef struct {
        int         c;
        logic [1:0] t0;
        logic [2:0] t1;
        logic       p0;
        logic       p1;
        logic [1:0] g0;
        logic [2:0] g1;
    } exp_t;

    exp_t q[$];
    int   tests  = 0;
    int   failed = 0;

    // Reference state: ticks fall where the enabled cycles since the last clear are a multiple of P+1.
    int   nch[2]      = '{2, 3};
    int   def_p[2][3] = '{'{4, 2, 0}, '{4, 2, 6}};
    int   per_m[2][3];
    int   run_m[2][3];
    logic tog_m[2][3];
    int   cyc_c;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 3; k++) begin
                per_m[i][k] = def_p[i][k];
                run_m[i][k] = 0;
                tog_m[i][k] = 1'b0;
            end
        end
        cyc_c = 0;
    endtask

    task automatic rst_cycles(input int n);
        exp_t x;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            rst_n = 1'b0; en = 1'b0; sync = 1'b0; we0 = 1'b0; we1 = 1'b0;
            model_reset();
            x = '{c: 0, t0: '0, t1: '0, p0: 1'b0, p1: 1'b0, g0: '0, g1: '0};
            q.push_back(x);
        end
    endtask

    // One clock of stimulus; ch may be out of range for u_dut1, and u_dut0 only sees writes it can address.
    task automatic drive(input logic e, input logic s, input logic w, input int ch, input int p);
        exp_t       x;
        logic [2:0] tk[2];
        logic [2:0] tg[2];
        logic       hit;
        @(negedge clk);
        rst_n  = 1'b1;
        en     = e;
        sync   = s;
        we0    = w && (ch < 2);
        ch0    = ch[0:0];
        we1    = w;
        ch1    = ch[2:0];
        per_in = p[7:0];
        cyc_c++;
        for (int i = 0; i < 2; i++) begin
            tk[i] = '0;
            tg[i] = '0;
            for (int k = 0; k < nch[i]; k++) begin
                hit = w && (ch == k);
                if (hit || s) begin
                    run_m[i][k] = 0;
                end else if (e) begin
                    run_m[i][k]++;
                    tk[i][k] = ((run_m[i][k] % (per_m[i][k] + 1)) == 0);
                end
                if (hit) per_m[i][k] = p;
                tog_m[i][k] = tog_m[i][k] ^ tk[i][k];
                tg[i][k]    = tog_m[i][k];
            end
        end
        x.c  = cyc_c;
        x.t0 = tk[0][1:0];
        x.t1 = tk[1];
        x.p0 = ((cyc_c % 2) == 0);
        x.p1 = 1'b1;
        x.g0 = tg[0][1:0];
        x.g1 = tg[1];
        q.push_back(x);
    endtask

    task automatic run(input int n, input logic e);
        for (int j = 0; j < n; j++) drive(e, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic chk(input string nm, input int c, input logic [2:0] got, input logic [2:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s cycle=%0d got=%b expected=%b", nm, c, got, exp);
        end
    endtask

    // Monitor: one DUT output set per clock, compared against the oldest queued expectation.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("tick0", x.c, {1'b0, tick0}, {1'b0, x.t0});
                chk("pix0",  x.c, {2'b0, pix0},  {2'b0, x.p0});
                chk("tick1", x.c, tick1,         x.t1);
                chk("pix1",  x.c, {2'b0, pix1},  {2'b0, x.p1});
`ifdef TICKGEN_TOGGLE_EN
                chk("toggle0", x.c, {1'b0, tog0}, {1'b0, x.g0});
                chk("toggle1", x.c, tog1,         x.g1);
`endif
            end
        end
    end

    initial begin
        int waited;
        rst_n = 1'b0; en = 1'b0; sync = 1'b0; we0 = 1'b0; we1 = 1'b0;
        ch0 = '0; ch1 = '0; per_in = '0;
        model_reset();

        rst_cycles(3);
        run(16, 1'b1);                      // default periods: ch0 every 5, ch1 every 3
        drive(1'b1, 1'b0, 1'b1, 0, 0);      // ch0 P=0: quiet once, then every cycle
        run(5, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 3, 1);      // nonexistent channel on u_dut1
        run(4, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 2, 3);      // u_dut1 ch2 only
        drive(1'b1, 1'b0, 1'b1, 0, 4);
        drive(1'b1, 1'b0, 1'b1, 1, 2);
        run(3, 1'b1);
        run(7, 1'b0);                       // freeze mid-count
        run(12, 1'b1);
        run(4, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 0, 0);      // phase align
        run(34, 1'b1);                      // joint ticks 15 and 30 cycles after the sync; ch0 then at terminal count
        drive(1'b1, 1'b0, 1'b1, 0, 4);      // write lands on ch0 terminal count
        run(12, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1, 3);      // sync together with a write
        run(10, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 0, 1);      // write while frozen
        run(3, 1'b0);
        run(6, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 0, 0);      // sync while frozen
        run(4, 1'b1);
        run(2, 1'b1);
        rst_cycles(2);                      // mid-count reset restores default periods
        run(12, 1'b1);

        @(negedge clk);
        en = 1'b0;
        waited = 0;
        while (q.size() > 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (q.size() > 0) begin
            tests++;
            failed++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
